// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_rr family.
package stream_mux_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    // Channel-index width: max(1, clog2(n)).
    function automatic int unsigned chan_w(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational wrapping priority search: first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_grant #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [CW-1:0] grant,
    output logic          grant_valid
);

    logic [N-1:0] req_sh;

    // Walk N positions starting at ptr; the first hit wins.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        req_sh      = '0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            req_sh = req >> idx;
            if (!grant_valid && req_sh[0]) begin
                grant_valid = 1'b1;
                grant       = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with one registered output stage;
// fixed (sel) or round-robin selection chosen at elaboration.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int unsigned W    = 16,
    parameter int unsigned N    = 4,
    parameter int unsigned MODE = MODE_RR,
    localparam int unsigned CW  = chan_w(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic [CW-1:0]   sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [CW-1:0]   out_chan
);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [CW-1:0]   out_chan_q,  out_chan_d;
    logic [CW-1:0]   ptr_q,       ptr_d;

    logic [N-1:0]    req_c;
    logic [CW-1:0]   start_c;
    logic [CW-1:0]   grant_c;
    logic            grant_valid_c;
    logic            load_c;
    logic            xfer_c;

    // Arbiter inputs: round-robin searches all requests from ptr; fixed mode
    // masks down to the selected channel so both modes share one search path.
    always_comb begin
        req_c   = in_valid;
        start_c = ptr_q;
        if (MODE == MODE_FIXED) begin
            req_c   = '0;
            start_c = '0;
            if (32'(sel) < N) begin
                start_c = sel;
                req_c   = in_valid & (N'(1) << sel);
            end
        end
    end

    rr_grant #(
        .N  (N),
        .CW (CW)
    ) u_grant (
        .req         (req_c),
        .ptr         (start_c),
        .grant       (grant_c),
        .grant_valid (grant_valid_c)
    );

    // Handshake decode; in_ready is forced low while reset is asserted.
    always_comb begin
        load_c   = !out_valid_q || out_ready;
        xfer_c   = rst_n && load_c && grant_valid_c;
        in_ready = xfer_c ? (N'(1) << grant_c) : '0;
    end

    // Next state of the output register and round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load_c) begin
            out_valid_d = xfer_c;
        end
        if (xfer_c) begin
            out_data_d = in_data[32'(grant_c)*W +: W];
            out_chan_d = grant_c;
            if (MODE == MODE_RR) begin
                ptr_d = (32'(grant_c) == N - 1) ? '0 : CW'(32'(grant_c) + 1);
            end
        end
    end

    // State registers; reset drops any pending beat immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed, table-driven bench for stream_mux_rr: round-robin N=4, round-robin
// N=3 (non power of two) and fixed-select N=4 instances share clock and reset.
module tb_stream_mux_rr;

    typedef struct {
        int unsigned dut;       // 0: RR N=4, 1: RR N=3, 2: fixed N=4
        logic [3:0]  iv;
        logic        ordy;
        logic [1:0]  sel;
        logic [63:0] d;
        logic [3:0]  exp_rdy;   // in_ready before the edge
        logic        exp_ov;    // out_valid after the edge
        logic [1:0]  exp_chan;  // checked only when exp_ov
        logic [15:0] exp_data;  // checked only when exp_ov
    } vec_t;

    localparam logic [63:0] DA = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    localparam logic [63:0] DP = {16'h00A3, 16'h00A2, 16'h1234, 16'h00A0};
    localparam logic [63:0] DB = {16'h0000, 16'h00B2, 16'h00B1, 16'h00B0};
    localparam logic [63:0] DC = {16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0};

    logic clk;
    logic rst_n;

    logic [3:0]  iv4, rdy4, ivf, rdyf;
    logic [2:0]  iv3, rdy3;
    logic [63:0] d4, df;
    logic [47:0] d3;
    logic [1:0]  sel4, sel3, self, oc4, oc3, ocf;
    logic        ov4, ov3, ovf, ordy4, ordy3, ordyf;
    logic [15:0] od4, od3, odf;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    vec_t        vecs[$];

    stream_mux_rr #(.W(16), .N(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4), .in_data(d4),
        .sel(sel4), .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_chan(oc4)
    );

    stream_mux_rr #(.W(16), .N(3), .MODE(1)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(rdy3), .in_data(d3),
        .sel(sel3), .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_chan(oc3)
    );

    stream_mux_rr #(.W(16), .N(4), .MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .in_valid(ivf), .in_ready(rdyf), .in_data(df),
        .sel(self), .out_valid(ovf), .out_ready(ordyf), .out_data(odf), .out_chan(ocf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input int unsigned dut, input logic [3:0] iv, input logic ordy,
                                input logic [1:0] sel, input logic [63:0] d, input logic [3:0] er,
                                input logic eov, input logic [1:0] ec, input logic [15:0] ed);
        vec_t v;
        v.dut = dut; v.iv = iv; v.ordy = ordy; v.sel = sel; v.d = d;
        v.exp_rdy = er; v.exp_ov = eov; v.exp_chan = ec; v.exp_data = ed;
        vecs.push_back(v);
    endfunction

    task automatic idle_all();
        iv4 = '0; ordy4 = 1'b0;
        iv3 = '0; ordy3 = 1'b0;
        ivf = '0; ordyf = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        idle_all();
        case (v.dut)
            0: begin iv4 = v.iv;      ordy4 = v.ordy; sel4 = v.sel; d4 = v.d;       end
            1: begin iv3 = v.iv[2:0]; ordy3 = v.ordy; sel3 = v.sel; d3 = v.d[47:0]; end
            default: begin ivf = v.iv; ordyf = v.ordy; self = v.sel; df = v.d;      end
        endcase
    endtask

    task automatic sample(input int unsigned dut, output logic [3:0] rdy, output logic ov,
                          output logic [1:0] ch, output logic [15:0] dat);
        case (dut)
            0: begin rdy = rdy4;          ov = ov4; ch = oc4; dat = od4; end
            1: begin rdy = {1'b0, rdy3};  ov = ov3; ch = oc3; dat = od3; end
            default: begin rdy = rdyf;    ov = ovf; ch = ocf; dat = odf; end
        endcase
    endtask

    initial begin
        logic [3:0]  a_rdy;
        logic        a_ov;
        logic [1:0]  a_ch;
        logic [15:0] a_dat;

        // RR N=4: fairness, then back-pressure with a 0x1234 beat, drain, skip.
        add(0, 4'b1111, 1, 0, DA, 4'b0001, 1, 0, 16'h00A0);
        add(0, 4'b1111, 1, 0, DA, 4'b0010, 1, 1, 16'h00A1);
        add(0, 4'b1111, 1, 0, DA, 4'b0100, 1, 2, 16'h00A2);
        add(0, 4'b1111, 1, 0, DA, 4'b1000, 1, 3, 16'h00A3);
        add(0, 4'b1111, 1, 0, DA, 4'b0001, 1, 0, 16'h00A0);
        add(0, 4'b1111, 1, 0, DP, 4'b0010, 1, 1, 16'h1234);
        add(0, 4'b1111, 0, 0, DP, 4'b0000, 1, 1, 16'h1234);
        add(0, 4'b1111, 0, 0, DP, 4'b0000, 1, 1, 16'h1234);
        add(0, 4'b1111, 0, 0, DP, 4'b0000, 1, 1, 16'h1234);
        add(0, 4'b1111, 1, 0, DP, 4'b0100, 1, 2, 16'h00A2);
        add(0, 4'b0000, 1, 0, DP, 4'b0000, 0, 0, 16'h0000);
        add(0, 4'b1000, 0, 0, DP, 4'b1000, 1, 3, 16'h00A3);
        add(0, 4'b0010, 0, 0, DP, 4'b0000, 1, 3, 16'h00A3);
        add(0, 4'b0010, 1, 0, DP, 4'b0010, 1, 1, 16'h1234);
        // RR N=3: reach ptr=2, skip empty channel 2 and wrap; ptr wraps 2 -> 0.
        add(1, 4'b0010, 1, 0, DB, 4'b0010, 1, 1, 16'h00B1);
        add(1, 4'b0011, 1, 0, DB, 4'b0001, 1, 0, 16'h00B0);
        add(1, 4'b0110, 1, 0, DB, 4'b0010, 1, 1, 16'h00B1);
        add(1, 4'b0100, 1, 0, DB, 4'b0100, 1, 2, 16'h00B2);
        add(1, 4'b0111, 1, 0, DB, 4'b0001, 1, 0, 16'h00B0);
        add(1, 4'b0000, 1, 0, DB, 4'b0000, 0, 0, 16'h0000);
        // Fixed N=4: no grant on idle sel, sel change during stall ignored.
        add(2, 4'b1011, 1, 2, DC, 4'b0000, 0, 0, 16'h0000);
        add(2, 4'b1011, 1, 3, DC, 4'b1000, 1, 3, 16'h00C3);
        add(2, 4'b1011, 0, 0, DC, 4'b0000, 1, 3, 16'h00C3);
        add(2, 4'b1011, 1, 0, DC, 4'b0001, 1, 0, 16'h00C0);
        add(2, 4'b1011, 1, 1, DC, 4'b0010, 1, 1, 16'h00C1);
        add(2, 4'b1111, 1, 2, DC, 4'b0100, 1, 2, 16'h00C2);

        // Reset held with every channel requesting.
        rst_n = 1'b0;
        sel4 = '0; sel3 = '0; self = '0;
        d4 = DA; d3 = DB[47:0]; df = DC;
        iv4 = 4'b1111; iv3 = 3'b111; ivf = 4'b1111;
        ordy4 = 1'b1; ordy3 = 1'b1; ordyf = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(ov4), 64'd0);
        chk("reset in_ready", 64'(rdy4), 64'd0);
        chk("reset out_data", 64'(od4), 64'd0);
        chk("reset out_chan", 64'(oc4), 64'd0);
        chk("reset in_ready n3", 64'(rdy3), 64'd0);
        chk("reset out_valid fixed", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_all();

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            sample(vecs[i].dut, a_rdy, a_ov, a_ch, a_dat);
            chk($sformatf("v%0d in_ready", i), 64'(a_rdy), 64'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            sample(vecs[i].dut, a_rdy, a_ov, a_ch, a_dat);
            chk($sformatf("v%0d out_valid", i), 64'(a_ov), 64'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                chk($sformatf("v%0d out_chan", i), 64'(a_ch), 64'(vecs[i].exp_chan));
                chk($sformatf("v%0d out_data", i), 64'(a_dat), 64'(vecs[i].exp_data));
            end
        end

        // Async reset mid-stream: rr4 is holding a stalled beat, ptr at 2.
        @(negedge clk);
        idle_all();
        iv4 = 4'b1111; ordy4 = 1'b0; d4 = DA;
        #2;
        chk("pre-reset out_valid", 64'(ov4), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 64'(ov4), 64'd0);
        chk("async reset in_ready", 64'(rdy4), 64'd0);
        chk("async reset out_data", 64'(od4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ordy4 = 1'b1;
        #1;
        chk("post-reset in_ready", 64'(rdy4), 64'b0001);
        @(posedge clk);
        #1;
        chk("post-reset out_chan", 64'(oc4), 64'd0);
        chk("post-reset out_data", 64'(od4), 64'h00A0);
        @(negedge clk);
        #1;
        chk("post-reset next in_ready", 64'(rdy4), 64'b0010);
        @(posedge clk);
        #1;
        chk("post-reset next out_chan", 64'(oc4), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
